mtm_alu_rx_ctrl: RTL and testbench

Input-side controller for the serial ALU. It deserializes 11-bit frames from `sin`, assembles one 8-DATA + 1-CMD command, and checks frame count, CRC4 and opcode. A valid command is issued to the ALU core over a valid/ready handshake; an invalid one is issued as a 3-bit error code to the output serializer. The block sits between the chip pin `sin` and the ALU core and its serializer, and stalls intake while either downstream is busy.

---
 rtl/mtm_alu_rx_ctrl_if.sv | 22 ++
 rtl/mtm_alu_rx_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mtm_alu_rx_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_rx_ctrl_if.sv
// Handshake bundle between the serial-ALU input controller and its two consumers:
// the ALU core (operands/opcode) and the output serializer (error code).
interface mtm_alu_rx_ctrl_if;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_code;
    logic        op_valid;
    logic        op_ready;
    logic        err_valid;
    logic [2:0]  err_flags;
    logic        err_ready;

    modport master (
        output op_a, op_b, op_code, op_valid, err_valid, err_flags,
        input  op_ready, err_ready
    );

    modport slave (
        input  op_a, op_b, op_code, op_valid, err_valid, err_flags,
        output op_ready, err_ready
    );
endinterface

// File: rtl/mtm_alu_rx_ctrl.sv
// Serial ALU input controller: deserializes 11-bit frames from sin, assembles
// 8 DATA + 1 CMD, validates count/CRC4/opcode and issues a command or an error code.
module mtm_alu_rx_ctrl #(
    parameter int N_DATA    = 8,
    parameter bit CRC_CHECK = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic busy,
    mtm_alu_rx_ctrl_if.master alu
);

    typedef enum logic [2:0] {IDLE, RX, EVAL, ISSUE, ERROR, REARM} state_t;

    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;
    localparam logic [3:0] N_LAST   = 4'(N_DATA);

    state_t      state, state_next;
    logic [3:0]  bit_cnt, bit_cnt_next;
    logic [8:0]  rx_shift, rx_shift_next;
    logic [3:0]  frame_cnt, frame_cnt_next;
    logic [3:0]  crc, crc_next;
    logic [63:0] sr, sr_next;
    logic [31:0] op_a, op_a_next;
    logic [31:0] op_b, op_b_next;
    logic [2:0]  op_code, op_code_next;
    logic        op_valid, op_valid_next;
    logic        err_valid, err_valid_next;
    logic [2:0]  err_flags, err_flags_next;

    logic [2:0]  rx_op;
    logic [3:0]  rx_crc;
    logic [3:0]  crc_final;
    logic        op_legal;

    // LFSR for x^4+x+1, MSB first; consumes the top nbits of data.
    function automatic logic [3:0] crc4_update(input logic [3:0] crc_in,
                                               input logic [7:0] data,
                                               input int nbits);
        logic [3:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (i >= 8 - nbits) begin
                fb = c[3] ^ data[i];
                c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
            end
        end
        return c;
    endfunction

    assign rx_op     = rx_shift[6:4];
    assign rx_crc    = rx_shift[3:0];
    assign crc_final = crc4_update(crc, {1'b1, rx_op, 4'b0000}, 4);
    assign op_legal  = (rx_op == 3'b000) || (rx_op == 3'b001) ||
                       (rx_op == 3'b100) || (rx_op == 3'b101);

    assign busy          = (state != IDLE);
    assign alu.op_a      = op_a;
    assign alu.op_b      = op_b;
    assign alu.op_code   = op_code;
    assign alu.op_valid  = op_valid;
    assign alu.err_valid = err_valid;
    assign alu.err_flags = err_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= REARM;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            frame_cnt <= '0;
            crc       <= '0;
            sr        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= '0;
            op_valid  <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            rx_shift  <= rx_shift_next;
            frame_cnt <= frame_cnt_next;
            crc       <= crc_next;
            sr        <= sr_next;
            op_a      <= op_a_next;
            op_b      <= op_b_next;
            op_code   <= op_code_next;
            op_valid  <= op_valid_next;
            err_valid <= err_valid_next;
            err_flags <= err_flags_next;
        end
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        rx_shift_next  = rx_shift;
        frame_cnt_next = frame_cnt;
        crc_next       = crc;
        sr_next        = sr;
        op_a_next      = op_a;
        op_b_next      = op_b;
        op_code_next   = op_code;
        op_valid_next  = op_valid;
        err_valid_next = err_valid;
        err_flags_next = err_flags;

        case (state)
            REARM: begin
                if (sin) state_next = IDLE;
            end

            IDLE: begin
                if (!sin) begin
                    state_next   = RX;
                    bit_cnt_next = '0;
                end
            end

            RX: begin
                if (bit_cnt == 4'd9) begin
                    if (!sin) begin
                        state_next     = ERROR;
                        err_valid_next = 1'b1;
                        err_flags_next = ERR_DATA;
                    end else if (!rx_shift[8]) begin
                        if (frame_cnt == N_LAST) begin
                            state_next     = ERROR;
                            err_valid_next = 1'b1;
                            err_flags_next = ERR_DATA;
                        end else begin
                            // CRC advances per byte so EVAL only folds in {1, op}.
                            sr_next        = {sr[55:0], rx_shift[7:0]};
                            crc_next       = crc4_update(crc, rx_shift[7:0], 8);
                            frame_cnt_next = frame_cnt + 4'd1;
                            state_next     = IDLE;
                        end
                    end else begin
                        state_next = EVAL;
                    end
                end else begin
                    rx_shift_next = {rx_shift[7:0], sin};
                    bit_cnt_next  = bit_cnt + 4'd1;
                end
            end

            EVAL: begin
                if (frame_cnt != N_LAST) begin
                    state_next     = ERROR;
                    err_valid_next = 1'b1;
                    err_flags_next = ERR_DATA;
                end else if (CRC_CHECK && (rx_crc != crc_final)) begin
                    state_next     = ERROR;
                    err_valid_next = 1'b1;
                    err_flags_next = ERR_CRC;
                end else if (!op_legal) begin
                    state_next     = ERROR;
                    err_valid_next = 1'b1;
                    err_flags_next = ERR_OP;
                end else begin
                    state_next    = ISSUE;
                    op_valid_next = 1'b1;
                    op_a_next     = sr[31:0];
                    op_b_next     = sr[63:32];
                    op_code_next  = rx_op;
                end
            end

            ISSUE: begin
                if (alu.op_ready) begin
                    op_valid_next  = 1'b0;
                    frame_cnt_next = '0;
                    crc_next       = '0;
                    state_next     = REARM;
                end
            end

            ERROR: begin
                if (alu.err_ready) begin
                    err_valid_next = 1'b0;
                    frame_cnt_next = '0;
                    crc_next       = '0;
                    state_next     = REARM;
                end
            end

            default: state_next = REARM;
        endcase
    end

    a_exclusive_valid: assert property (@(posedge clk) disable iff (rst)
        !(op_valid && err_valid));
    a_onehot_flags: assert property (@(posedge clk) disable iff (rst)
        $onehot0(err_flags));

endmodule

// File: tb/tb_mtm_alu_rx_ctrl.sv
// Scoreboard bench for mtm_alu_rx_ctrl: frames are driven on sin, expected results
// are queued when a command is sent and popped when the DUT raises a valid.
module tb_mtm_alu_rx_ctrl;

    typedef struct packed {
        logic        ov;
        logic        ev;
        logic [2:0]  flags;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  code;
        logic [7:0]  lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin_drv = 1'b1;
    logic sel = 1'b0;
    logic sin0, sin1, busy0, busy1;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mtm_alu_rx_ctrl_if if0();
    mtm_alu_rx_ctrl_if if1();

    assign sin0 = sel ? 1'b1 : sin_drv;
    assign sin1 = sel ? sin_drv : 1'b1;

    mtm_alu_rx_ctrl #(.N_DATA(8), .CRC_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .sin(sin0), .busy(busy0), .alu(if0)
    );

    mtm_alu_rx_ctrl #(.N_DATA(8), .CRC_CHECK(1'b0)) dut_nocrc (
        .clk(clk), .rst(rst), .sin(sin1), .busy(busy1), .alu(if1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference CRC by polynomial long division of msg * x^4 by 10011.
    function automatic logic [3:0] crc_ref(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic res_t mk_ok(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] code, input int lat);
        res_t e;
        e = '0;
        e.ov = 1'b1; e.a = a; e.b = b; e.code = code; e.lat = 8'(lat);
        return e;
    endfunction

    function automatic res_t mk_err(input logic [2:0] flags, input int lat);
        res_t e;
        e = '0;
        e.ev = 1'b1; e.flags = flags; e.lat = 8'(lat);
        return e;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("ov=%b ev=%b flags=%b a=%h b=%h code=%b lat=%0d",
                         r.ov, r.ev, r.flags, r.a, r.b, r.code, r.lat);
    endfunction

    task automatic idle(input int n);
        sin_drv = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            sin_drv = f[i];
            @(negedge clk);
        end
        sin_drv = 1'b1;
    endtask

    // Sends n DATA frames of {b,a} MSB byte first, then an optional CMD frame.
    task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input int n_data,
                            input logic [2:0] op, input bit good_crc, input bit with_cmd);
        logic [63:0] ba;
        logic [3:0]  c;
        ba = {b, a};
        c  = good_crc ? crc_ref({b, a, 1'b1, op}) : 4'b0000;
        for (int k = 0; k < n_data; k++)
            send_frame(1'b0, (k < 8) ? ba[63 - 8*k -: 8] : 8'hA5, 1'b1);
        if (with_cmd) send_frame(1'b1, {1'b0, op, c}, 1'b1);
    endtask

    // Waits for op_valid/err_valid; lat counts negedges after the last stop bit.
    task automatic wait_result(input bit which, output res_t obs, output bit got);
        logic ov, ev;
        obs = '0;
        got = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            ov = which ? if1.op_valid : if0.op_valid;
            ev = which ? if1.err_valid : if0.err_valid;
            if (ov || ev) begin
                obs.ov  = ov;
                obs.ev  = ev;
                obs.lat = 8'(k);
                if (ov) begin
                    obs.a    = which ? if1.op_a : if0.op_a;
                    obs.b    = which ? if1.op_b : if0.op_b;
                    obs.code = which ? if1.op_code : if0.op_code;
                end
                if (ev) obs.flags = which ? if1.err_flags : if0.err_flags;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({if0.op_valid, if0.err_valid, if0.err_flags, if0.op_a, if0.op_b, if0.op_code} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got ov=%b ev=%b flags=%b a=%h b=%h code=%b, expected all zero",
                     if0.op_valid, if0.err_valid, if0.err_flags, if0.op_a, if0.op_b, if0.op_code);
        end
        rst = 1'b0;
        idle(2);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy: got busy=%b, expected 0", busy0);
        end
    endtask

    task automatic test_valid_cmd();
        res_t obs, exp;
        bit   got;
        sb.push_back(mk_ok(32'h11111111, 32'h22222222, 3'b100, 1));
        send_cmd(32'h22222222, 32'h11111111, 8, 3'b100, 1'b1, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL valid_cmd: got %s, expected %s", fmt(obs), fmt(exp));
        end
        @(negedge clk);
        checks++;
        if (if0.op_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL valid_one_cycle: got op_valid=%b, expected 0", if0.op_valid);
        end
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_after_rearm: got busy=%b, expected 0", busy0);
        end
        idle(1);
    endtask

    task automatic test_bad_crc();
        res_t obs, exp;
        bit   got;
        sb.push_back(mk_err(3'b010, 1));
        send_cmd(32'h22222222, 32'h11111111, 8, 3'b100, 1'b0, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL bad_crc: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
        sel = 1'b1;
        sb.push_back(mk_ok(32'h11111111, 32'h22222222, 3'b100, 1));
        send_cmd(32'h22222222, 32'h11111111, 8, 3'b100, 1'b0, 1'b1);
        wait_result(1'b1, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL no_crc_check: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
        sel = 1'b0;
        idle(1);
    endtask

    task automatic test_bad_opcode();
        res_t obs, exp;
        bit   got;
        sb.push_back(mk_err(3'b001, 1));
        send_cmd(32'h22222222, 32'h11111111, 8, 3'b010, 1'b1, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL bad_opcode: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
    endtask

    task automatic test_frame_count();
        res_t obs, exp;
        bit   got;
        sb.push_back(mk_err(3'b100, 1));
        send_cmd(32'hCAFEF00D, 32'h12345678, 7, 3'b100, 1'b1, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL too_few_frames: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
        sb.push_back(mk_err(3'b100, 0));
        send_cmd(32'hCAFEF00D, 32'h12345678, 9, 3'b100, 1'b1, 1'b0);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL too_many_frames: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
    endtask

    task automatic test_back_pressure();
        res_t        obs, exp;
        bit          got;
        logic [10:0] f;
        logic [68:0] held, now_v;
        if0.op_ready = 1'b0;
        sb.push_back(mk_ok(32'h0000FFFF, 32'hA5A5A5A5, 3'b101, 1));
        send_cmd(32'hA5A5A5A5, 32'h0000FFFF, 8, 3'b101, 1'b1, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL stall_cmd: got %s, expected %s", fmt(obs), fmt(exp));
        end
        held = {1'b1, 32'h0000FFFF, 32'hA5A5A5A5, 3'b101, 1'b1};
        f = {1'b0, 1'b0, 8'h3C, 1'b1};
        for (int c = 0; c < 20; c++) begin
            sin_drv = (c < 11) ? f[10 - c] : 1'b1;
            @(negedge clk);
            now_v = {if0.op_valid, if0.op_a, if0.op_b, if0.op_code, busy0};
            checks++;
            if (now_v !== held) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d: got %h, expected %h", c, now_v, held);
            end
        end
        sin_drv = 1'b1;
        if0.op_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.op_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_release: got op_valid=%b, expected 0", if0.op_valid);
        end
        idle(2);
        sb.push_back(mk_ok(32'h87654321, 32'h0BADBEEF, 3'b000, 1));
        send_cmd(32'h0BADBEEF, 32'h87654321, 8, 3'b000, 1'b1, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL after_stall_cmd: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
    endtask

    task automatic test_reset_robust();
        res_t        obs, exp;
        bit          got;
        int          bad;
        logic [10:0] f;
        send_cmd(32'h01020304, 32'h05060708, 4, 3'b100, 1'b1, 1'b0);
        f = {1'b0, 1'b0, 8'hF0, 1'b1};
        for (int i = 10; i >= 5; i--) begin
            sin_drv = f[i];
            @(negedge clk);
        end
        sin_drv = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if ({if0.op_valid, if0.err_valid, if0.err_flags, if0.op_a, if0.op_b, if0.op_code} !== '0
                || busy0 !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL rearm_hold: %0d bad cycles with sin low after reset, expected 0", bad);
        end
        idle(2);
        sb.push_back(mk_ok(32'hDEADBEEF, 32'h00C0FFEE, 3'b001, 1));
        send_cmd(32'h00C0FFEE, 32'hDEADBEEF, 8, 3'b001, 1'b1, 1'b1);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL post_reset_cmd: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
        sb.push_back(mk_err(3'b100, 0));
        send_frame(1'b0, 8'h55, 1'b0);
        wait_result(1'b0, obs, got);
        exp = sb.pop_front();
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("[TB] FAIL bad_stop: got %s, expected %s", fmt(obs), fmt(exp));
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        res_t        obs, exp;
        bit          got;
        logic [31:0] a, b;
        logic [2:0]  ops [3];
        ops = '{3'b000, 3'b001, 3'b101};
        for (int n = 0; n < 3; n++) begin
            a = $urandom();
            b = $urandom();
            sb.push_back(mk_ok(a, b, ops[n], 1));
            send_cmd(b, a, 8, ops[n], 1'b1, 1'b1);
            wait_result(1'b0, obs, got);
            exp = sb.pop_front();
            checks++;
            if (!got || obs !== exp) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: got %s, expected %s", n, fmt(obs), fmt(exp));
            end
            idle(2);
        end
    endtask

    initial begin
        if0.op_ready  = 1'b1;
        if0.err_ready = 1'b1;
        if1.op_ready  = 1'b1;
        if1.err_ready = 1'b1;
        test_reset();
        test_valid_cmd();
        test_bad_crc();
        test_bad_opcode();
        test_frame_count();
        test_back_pressure();
        test_reset_robust();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
